// File: rtl/ag_ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes the raw bus, detects ps2_clk
// falling edges, assembles 11-bit frames and decodes E0/F0 prefixes into
// code/released/extended with a one-cycle code_valid strobe.
// Optional glitch filter on the synchronized ps2_clk: define AG_PS2_FILTER_EN.
//
// state | meaning
// IDLE  | waiting for a start bit (data=0 on a ps2_clk falling edge)
// RECV  | shifting in D0..D7, parity, stop; inactivity timer running
// CHECK | one cycle: verify parity/stop, handle prefix or emit code
module ag_ps2_rx #(
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FILT_LEN       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ps2_bus,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       released,
  output logic       extended,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t      state;
  logic [1:0]  sync1;
  logic [1:0]  sync2;
  logic        clk_use;
  logic        clk_prev;
  logic        fall;
  logic        data_bit;
  logic [9:0]  shift;
  logic [3:0]  bit_cnt;
  logic [TW-1:0] timer;
  logic        rel;
  logic        ext;
  logic        parity_ok;
  logic        stop_ok;

  // FILT_LEN only matters with the filter; this keeps it referenced in every build.
  if (FILT_LEN > 0) begin : g_filt_len_ref
  end

  // Two-flop synchronizer on both bus bits; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= ps2_bus;
      sync2 <= sync1;
    end
  end

`ifdef AG_PS2_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic [FW-1:0] filt_cnt;

  // Glitch filter: accept a new ps2_clk level only after FILT_LEN equal samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_use  <= 1'b1;
      filt_cnt <= '0;
    end else if (sync2[1] == clk_use) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
      clk_use  <= sync2[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end
`else
  assign clk_use = sync2[1];
`endif

  // Previous ps2_clk level for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) clk_prev <= 1'b1;
    else     clk_prev <= clk_use;
  end

  assign fall      = clk_prev & ~clk_use;
  assign data_bit  = sync2[0];
  assign parity_ok = ^shift[8:0];
  assign stop_ok   = shift[9];

  // Frame reception, error detection and prefix decoding.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      timer      <= '0;
      rel        <= 1'b0;
      ext        <= 1'b0;
      code       <= 8'h00;
      code_valid <= 1'b0;
      released   <= 1'b0;
      extended   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (fall && !data_bit) begin
            state   <= RECV;
            bit_cnt <= '0;
          end
        end
        RECV: begin
          if (fall) begin
            shift <= {data_bit, shift[9:1]};
            timer <= '0;
            if (bit_cnt == 4'd9) begin
              state   <= CHECK;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err <= 1'b1;
            rel       <= 1'b0;
            ext       <= 1'b0;
            timer     <= '0;
            bit_cnt   <= '0;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (parity_ok && stop_ok) begin
            if (shift[7:0] == 8'hE0) begin
              ext <= 1'b1;
            end else if (shift[7:0] == 8'hF0) begin
              rel <= 1'b1;
            end else begin
              code       <= shift[7:0];
              released   <= rel;
              extended   <= ext;
              code_valid <= 1'b1;
              rel        <= 1'b0;
              ext        <= 1'b0;
            end
          end else begin
            frame_err <= 1'b1;
            rel       <= 1'b0;
            ext       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ag_ps2_rx.sv
// Directed bench for ag_ps2_rx: a table of frames with expected decode
// results, plus sequences for timeout, idle quiet and mid-frame reset.
module tb_ag_ps2_rx;

  localparam int TO   = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid, released, extended, frame_err;

  int cyc = 0, fall_cyc = 0, valid_cyc = 0;
  int n_valid = 0, n_err = 0, n_overlap = 0;
  int n_tests = 0, n_fail = 0;

  typedef struct {
    string      name;
    logic [7:0] b;
    logic       par_flip;
    logic       stop_bit;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_code;
    logic       exp_rel;
    logic       exp_ext;
  } vec_t;

  vec_t vecs[16];

  ag_ps2_rx #(.TIMEOUT_CYCLES(TO), .FILT_LEN(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_bus   ({ps2_clk, ps2_data}),
    .code      (code),
    .code_valid(code_valid),
    .released  (released),
    .extended  (extended),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (code_valid) begin
      n_valid   = n_valid + 1;
      valid_cyc = cyc;
    end
    if (frame_err) n_err = n_err + 1;
    if (code_valid && frame_err) n_overlap = n_overlap + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop_bit, input int nbits);
    logic [10:0] bits;
    bits = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #2;
      ps2_data = bits[i];
      repeat (HALF) @(posedge clk);
      #2;
      ps2_clk  = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #2;
      ps2_clk = 1'b1;
    end
    @(posedge clk); #2;
    ps2_data = 1'b1;
  endtask

  task automatic chk_outputs(input string name, input logic [7:0] c, input logic r, input logic e);
    chk({name, "_code"}, {24'h0, code}, {24'h0, c});
    chk({name, "_rel"}, {31'h0, released}, {31'h0, r});
    chk({name, "_ext"}, {31'h0, extended}, {31'h0, e});
  endtask

  initial begin
    int v0, e0;

    vecs[0]  = '{"make_1c",    8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};
    vecs[1]  = '{"pre_f0",     8'hF0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[2]  = '{"brk_1c",     8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b1, 1'b0};
    vecs[3]  = '{"pre_e0",     8'hE0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b1, 1'b0};
    vecs[4]  = '{"pre_e0f0",   8'hF0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b1, 1'b0};
    vecs[5]  = '{"ext_brk_75", 8'h75, 1'b0, 1'b1, 1, 0, 8'h75, 1'b1, 1'b1};
    vecs[6]  = '{"make_29",    8'h29, 1'b0, 1'b1, 1, 0, 8'h29, 1'b0, 1'b0};
    vecs[7]  = '{"pre_f0b",    8'hF0, 1'b0, 1'b1, 0, 0, 8'h29, 1'b0, 1'b0};
    vecs[8]  = '{"bad_par",    8'h1C, 1'b1, 1'b1, 0, 1, 8'h29, 1'b0, 1'b0};
    vecs[9]  = '{"after_par",  8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 1'b0, 1'b0};
    vecs[10] = '{"pre_f0c",    8'hF0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[11] = '{"pre_f0e0",   8'hE0, 1'b0, 1'b1, 0, 0, 8'h1C, 1'b0, 1'b0};
    vecs[12] = '{"ext_brk_6b", 8'h6B, 1'b0, 1'b1, 1, 0, 8'h6B, 1'b1, 1'b1};
    vecs[13] = '{"bad_stop",   8'h5A, 1'b0, 1'b0, 0, 1, 8'h6B, 1'b1, 1'b1};
    vecs[14] = '{"pre_e0b",    8'hE0, 1'b0, 1'b1, 0, 0, 8'h6B, 1'b1, 1'b1};
    vecs[15] = '{"ext_5a",     8'h5A, 1'b0, 1'b1, 1, 0, 8'h5A, 1'b0, 1'b1};

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk_outputs("reset", 8'h00, 1'b0, 1'b0);
    chk("reset_valid", {31'h0, code_valid}, 32'h0);
    chk("reset_err", {31'h0, frame_err}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    for (int i = 0; i < 16; i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[i].b, vecs[i].par_flip, vecs[i].stop_bit, 11);
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk({vecs[i].name, "_nvalid"}, n_valid - v0, vecs[i].exp_valid);
      chk({vecs[i].name, "_nerr"}, n_err - e0, vecs[i].exp_err);
      chk_outputs(vecs[i].name, vecs[i].exp_code, vecs[i].exp_rel, vecs[i].exp_ext);
      if (vecs[i].exp_valid != 0)
        chk({vecs[i].name, "_latency"}, valid_cyc - fall_cyc, 4);
    end

    // Timeout: pending F0, then a 5-bit partial frame and a silent bus.
    send_frame(8'hF0, 1'b0, 1'b1, 11);
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    repeat (TO - 60) @(posedge clk);
    @(negedge clk);
    chk("timeout_early", n_err - e0, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("timeout_err", n_err - e0, 1);
    chk("timeout_nvalid", n_valid - v0, 0);
    send_frame(8'h1C, 1'b0, 1'b1, 11);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("after_to_nvalid", n_valid - v0, 1);
    chk_outputs("after_to", 8'h1C, 1'b0, 1'b0);

    // Quiet bus: timer must not run in IDLE.
    v0 = n_valid;
    e0 = n_err;
    repeat (3 * TO) @(posedge clk);
    @(negedge clk);
    chk("idle_nerr", n_err - e0, 0);
    chk("idle_nvalid", n_valid - v0, 0);
    chk_outputs("idle", 8'h1C, 1'b0, 1'b0);

    // Reset mid-frame with a pending F0.
    send_frame(8'hF0, 1'b0, 1'b1, 11);
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h33, 1'b0, 1'b1, 5);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (TO + 50) @(posedge clk);
    @(negedge clk);
    chk("rst_nvalid", n_valid - v0, 0);
    chk("rst_nerr", n_err - e0, 0);
    chk_outputs("rst_mid", 8'h00, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 11);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("after_rst_nvalid", n_valid - v0, 1);
    chk_outputs("after_rst", 8'h5A, 1'b0, 1'b0);

    chk("strobe_overlap", n_overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
